switch_allocator: RTL and testbench

- Credit-aware, round-robin switch allocator for the five-port mesh router (N, S, E, W, L).
- Takes per-input-FIFO head requests, already resolved to an output port by route computation.
- Grants each output to at most one input per cycle and drives the crossbar selects, input FIFO pops and output-port enables.
- Tracks downstream buffer credits per output and returns credits upstream for every popped flit.

---
 rtl/switch_allocator_if.sv | 36 +++
 rtl/switch_allocator.sv | 131 +++++++++++++
 tb/tb_switch_allocator.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/switch_allocator_if.sv
// -----------------------------------------------------------------------------
// switch_allocator_if
// Bundle between the router datapath and the switch allocator.
//   master : drives head requests (req_valid_i, req_dest_i) and downstream
//            credit pulses (credit_inc_i); observes allocation results.
//   slave  : the allocator; drives crossbar selects (out_sel_o), output
//            enables (out_en_o), FIFO pops (in_pop_o), upstream credit
//            returns (credit_ret_o), credit counts (credit_cnt_o) and the
//            sticky error flags (err_o).
// Port index everywhere: N=0, S=1, E=2, W=3, L=4.
// -----------------------------------------------------------------------------
interface switch_allocator_if #(
   parameter int CREDITS = 4
);
   localparam int CW = $clog2(CREDITS + 1);

   logic [4:0]      req_valid_i;
   logic [14:0]     req_dest_i;
   logic [4:0]      credit_inc_i;
   logic [14:0]     out_sel_o;
   logic [4:0]      out_en_o;
   logic [4:0]      in_pop_o;
   logic [4:0]      credit_ret_o;
   logic [5*CW-1:0] credit_cnt_o;
   logic [1:0]      err_o;

   modport master (
      output req_valid_i, req_dest_i, credit_inc_i,
      input  out_sel_o, out_en_o, in_pop_o, credit_ret_o, credit_cnt_o, err_o
   );

   modport slave (
      input  req_valid_i, req_dest_i, credit_inc_i,
      output out_sel_o, out_en_o, in_pop_o, credit_ret_o, credit_cnt_o, err_o
   );
endinterface

// File: rtl/switch_allocator.sv
// -----------------------------------------------------------------------------
// switch_allocator
// Credit-aware round-robin switch allocator for a five-port mesh router.
// Each output picks, in the same cycle, the first eligible input found by
// scanning from its priority pointer; the pointer then moves just past the
// winner. Per-output credit counters gate grants; every pop is echoed one
// cycle later as a credit return to the upstream router of that input.
//   clk  : router clock
//   rst  : synchronous, active-low reset
//   bus  : switch_allocator_if.slave (requests in, allocation results out)
// Parameters: CREDITS (downstream FIFO depth), PORT_MASK (existing ports).
// -----------------------------------------------------------------------------
module switch_allocator #(
   parameter int         CREDITS   = 4,
   parameter logic [4:0] PORT_MASK = 5'b11111
) (
   input  logic               clk,
   input  logic               rst,
   switch_allocator_if.slave  bus
);
   localparam int            CW       = $clog2(CREDITS + 1);
   localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
   // Destination codes 5..7 map to "absent" so one lookup covers both
   // out-of-range and masked-off destinations.
   localparam logic [7:0]    DEST_OK  = {3'b000, PORT_MASK};

   logic [2:0]      ptr_reg    [5];
   logic [CW-1:0]   credit_reg [5];
   logic [4:0]      credit_ret_reg;
   logic [1:0]      err_reg;

   logic [2:0]      dest     [5];
   logic [4:0][4:0] elig;       // elig[o][i]
   logic [4:0]      grant;
   logic [2:0]      win      [5];
   logic [4:0]      pop;
   logic [4:0]      illegal;
   logic [4:0]      overflow;

   genvar gi, gj;

   // Per-input decode and illegal-destination detection (masked inputs ignored).
   generate
      for (gi = 0; gi < 5; gi++) begin : g_in
         assign dest[gi]    = bus.req_dest_i[3*gi +: 3];
         assign illegal[gi] = PORT_MASK[gi] & bus.req_valid_i[gi] & ~DEST_OK[dest[gi]];
      end
   endgenerate

   // Per-output eligibility, round-robin pick, pointer and credit state.
   generate
      for (gi = 0; gi < 5; gi++) begin : g_out
         logic       found;
         logic [2:0] pick;
         logic [3:0] sum;
         logic [2:0] idx;

         for (gj = 0; gj < 5; gj++) begin : g_elig
            assign elig[gi][gj] = bus.req_valid_i[gj] & PORT_MASK[gj] & PORT_MASK[gi]
                                & (dest[gj] == 3'(gi)) & (credit_reg[gi] != '0);
         end

         always_comb begin
            found = 1'b0;
            pick  = 3'd0;
            sum   = 4'd0;
            idx   = 3'd0;
            for (int k = 0; k < 5; k++) begin
               sum = {1'b0, ptr_reg[gi]} + 4'(k);
               idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : 3'(sum);
               if (!found && elig[gi][idx]) begin
                  found = 1'b1;
                  pick  = idx;
               end
            end
         end

         assign grant[gi]    = found;
         assign win[gi]      = pick;
         // Overflow only counts when no grant consumes a credit this cycle.
         assign overflow[gi] = PORT_MASK[gi] & bus.credit_inc_i[gi] & ~found
                             & (credit_reg[gi] == CRED_MAX);

         assign bus.out_en_o[gi]          = rst & found;
         assign bus.out_sel_o[3*gi +: 3]  = (rst & found) ? pick : 3'd0;
         assign bus.credit_cnt_o[CW*gi +: CW] = credit_reg[gi];

         always_ff @(posedge clk) begin
            if (!rst) begin
               ptr_reg[gi]    <= 3'd0;
               credit_reg[gi] <= CRED_MAX;
            end else begin
               if (found) begin
                  ptr_reg[gi] <= (pick == 3'd4) ? 3'd0 : pick + 3'd1;
               end
               if (PORT_MASK[gi]) begin
                  if (found && !bus.credit_inc_i[gi]) begin
                     credit_reg[gi] <= credit_reg[gi] - 1'b1;
                  end else if (!found && bus.credit_inc_i[gi] && credit_reg[gi] != CRED_MAX) begin
                     credit_reg[gi] <= credit_reg[gi] + 1'b1;
                  end
               end
            end
         end
      end
   endgenerate

   // An input has one destination, so at most one output can select it.
   always_comb begin
      pop = 5'd0;
      for (int o = 0; o < 5; o++) begin
         if (grant[o]) begin
            pop[win[o]] = 1'b1;
         end
      end
   end

   assign bus.in_pop_o     = rst ? pop : 5'd0;
   assign bus.credit_ret_o = credit_ret_reg;
   assign bus.err_o        = err_reg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         credit_ret_reg <= 5'd0;
         err_reg        <= 2'b00;
      end else begin
         credit_ret_reg <= pop;
         err_reg        <= err_reg | {|illegal, |overflow};
      end
   end
endmodule

// File: tb/tb_switch_allocator.sv
// -----------------------------------------------------------------------------
// tb_switch_allocator
// Drives a full five-port allocator and a wedge (W absent) allocator with the
// same stimulus: directed scenarios with literal expectations, then random
// traffic checked every cycle against a distance-based round-robin model.
// -----------------------------------------------------------------------------
module tb_switch_allocator;
   localparam int         CREDITS = 4;
   localparam int         CW      = $clog2(CREDITS + 1);
   localparam logic [4:0] MASK_A  = 5'b11111;
   localparam logic [4:0] MASK_W  = 5'b10111;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [4:0]  s_valid = '0;
   logic [14:0] s_dest  = '0;
   logic [4:0]  s_inc   = '0;

   switch_allocator_if #(.CREDITS(CREDITS)) ifa ();
   switch_allocator_if #(.CREDITS(CREDITS)) ifw ();

   assign ifa.req_valid_i  = s_valid;
   assign ifa.req_dest_i   = s_dest;
   assign ifa.credit_inc_i = s_inc;
   assign ifw.req_valid_i  = s_valid;
   assign ifw.req_dest_i   = s_dest;
   assign ifw.credit_inc_i = s_inc;

   switch_allocator #(.CREDITS(CREDITS), .PORT_MASK(MASK_A)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
   switch_allocator #(.CREDITS(CREDITS), .PORT_MASK(MASK_W)) dut_w (.clk(clk), .rst(rst), .bus(ifw.slave));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d at %0t: actual %0h required %0h", name, k, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model (state after the last edge) --------
   int         m_ptr  [2][5];
   int         m_cred [2][5];
   logic [4:0] m_ret  [2];
   logic [1:0] m_err  [2];

   logic [4:0]      cm_mask, cm_en, cm_pop, a_en, a_pop, a_ret;
   logic [14:0]     cm_sel, a_sel;
   logic [5*CW-1:0] cm_cnt, a_cnt;
   logic [1:0]      a_err;
   int              cm_win [5];
   int              cm_best, cm_bestd, cm_d, cm_dst;

   initial begin
      for (int k = 0; k < 2; k++) begin
         for (int o = 0; o < 5; o++) begin
            m_ptr[k][o]  = 0;
            m_cred[k][o] = CREDITS;
         end
         m_ret[k] = '0;
         m_err[k] = '0;
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         cm_mask = (k == 0) ? MASK_A : MASK_W;
         cm_en = '0; cm_sel = '0; cm_pop = '0;
         for (int o = 0; o < 5; o++) begin
            cm_win[o] = -1;
            if (rst && cm_mask[o] && m_cred[k][o] > 0) begin
               // Winner = eligible input at the smallest rotational distance from the pointer.
               cm_best = -1; cm_bestd = 5;
               for (int i = 0; i < 5; i++) begin
                  if (cm_mask[i] && s_valid[i] && int'(s_dest[3*i +: 3]) == o) begin
                     cm_d = (i - m_ptr[k][o] + 5) % 5;
                     if (cm_d < cm_bestd) begin cm_bestd = cm_d; cm_best = i; end
                  end
               end
               cm_win[o] = cm_best;
               if (cm_best >= 0) begin
                  cm_en[o] = 1'b1;
                  cm_sel[3*o +: 3] = 3'(cm_best);
                  cm_pop[cm_best] = 1'b1;
               end
            end
         end
         for (int o = 0; o < 5; o++) cm_cnt[CW*o +: CW] = CW'(m_cred[k][o]);

         a_en  = (k == 0) ? ifa.out_en_o     : ifw.out_en_o;
         a_sel = (k == 0) ? ifa.out_sel_o    : ifw.out_sel_o;
         a_pop = (k == 0) ? ifa.in_pop_o     : ifw.in_pop_o;
         a_ret = (k == 0) ? ifa.credit_ret_o : ifw.credit_ret_o;
         a_cnt = (k == 0) ? ifa.credit_cnt_o : ifw.credit_cnt_o;
         a_err = (k == 0) ? ifa.err_o        : ifw.err_o;
         chk("model_out_en", k, 32'(a_en), 32'(cm_en));
         chk("model_out_sel", k, 32'(a_sel), 32'(cm_sel));
         chk("model_in_pop", k, 32'(a_pop), 32'(cm_pop));
         chk("model_credit_ret", k, 32'(a_ret), 32'(m_ret[k]));
         chk("model_credit_cnt", k, 32'(a_cnt), 32'(cm_cnt));
         chk("model_err", k, 32'(a_err), 32'(m_err[k]));

         // Advance the model by the coming edge (inputs are stable until then).
         if (!rst) begin
            for (int o = 0; o < 5; o++) begin m_ptr[k][o] = 0; m_cred[k][o] = CREDITS; end
            m_ret[k] = '0;
            m_err[k] = '0;
         end else begin
            m_ret[k] = cm_pop;
            for (int o = 0; o < 5; o++) begin
               if (cm_mask[o]) begin
                  if (cm_en[o] && !s_inc[o]) m_cred[k][o]--;
                  else if (!cm_en[o] && s_inc[o]) begin
                     if (m_cred[k][o] == CREDITS) m_err[k][0] = 1'b1;
                     else m_cred[k][o]++;
                  end
                  if (cm_en[o]) m_ptr[k][o] = (cm_win[o] + 1) % 5;
               end
            end
            for (int i = 0; i < 5; i++) begin
               cm_dst = int'(s_dest[3*i +: 3]);
               if (cm_mask[i] && s_valid[i] && (cm_dst > 4 || !cm_mask[cm_dst])) m_err[k][1] = 1'b1;
            end
         end
      end
   end

   // ---------------- directed + random stimulus ---------------------------
   function automatic logic [14:0] pack(input int d0, input int d1, input int d2, input int d3, input int d4);
      return {3'(d4), 3'(d3), 3'(d2), 3'(d1), 3'(d0)};
   endfunction

   task automatic set_in(input logic [4:0] v, input logic [14:0] d, input logic [4:0] inc);
      s_valid = v; s_dest = d; s_inc = inc;
   endtask

   task automatic next_edge();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      set_in('0, '0, '0);
      next_edge();
      rst = 1'b1;
   endtask

   int seq2 [6]    = '{0, 1, 4, 0, 1, 4};
   int en3  [8]    = '{1, 1, 1, 1, 0, 0, 0, 1};
   int cnt3 [8]    = '{3, 2, 1, 0, 0, 0, 1, 0};
   logic [14:0] all4;

   initial begin
      all4 = {5{3'd4}};
      // Reset held with every input asking for E.
      set_in(5'b11111, pack(2, 2, 2, 2, 2), '0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("rst_no_en", 0, 32'(ifa.out_en_o), 0);
         chk("rst_no_pop", 0, 32'(ifa.in_pop_o), 0);
         chk("rst_no_pop", 1, 32'(ifw.in_pop_o), 0);
         next_edge();
      end
      rst = 1'b1;
      @(negedge clk);
      chk("rst_credit_all4", 0, 32'(ifa.credit_cnt_o), 32'(all4));
      chk("first_grant_sel", 0, 32'(ifa.out_sel_o[8:6]), 0);
      chk("first_grant_en", 0, 32'(ifa.out_en_o), 32'(5'b00100));
      chk("first_grant_pop", 0, 32'(ifa.in_pop_o), 32'(5'b00001));
      $display("reset release: out_sel[E]=%0d out_en=%b", ifa.out_sel_o[8:6], ifa.out_en_o);
      next_edge();

      // Round robin among N, S, L on E with a credit back every cycle.
      do_reset();
      set_in(5'b10011, pack(2, 2, 2, 2, 2), 5'b00100);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("rr_sel", 0, 32'(ifa.out_sel_o[8:6]), 32'(seq2[c]));
         chk("rr_en", 0, 32'(ifa.out_en_o[2]), 1);
         $display("rr cycle %0d: out_sel[E]=%0d", c, ifa.out_sel_o[8:6]);
         next_edge();
         chk("rr_credit", 0, 32'(ifa.credit_cnt_o[8:6]), 4);
      end

      // Credit exhaustion on S, then one credit back at cycle 6.
      do_reset();
      for (int c = 0; c < 8; c++) begin
         set_in(5'b00001, pack(1, 0, 0, 0, 0), (c == 6) ? 5'b00010 : 5'b00000);
         @(negedge clk);
         chk("cred_en", 0, 32'(ifa.out_en_o[1]), 32'(en3[c]));
         $display("credit cycle %0d: out_en[S]=%0d", c, ifa.out_en_o[1]);
         next_edge();
         chk("cred_cnt", 0, 32'(ifa.credit_cnt_o[5:3]), 32'(cnt3[c]));
      end

      // Two simultaneous grants and their credit returns.
      do_reset();
      set_in(5'b00101, pack(4, 0, 1, 0, 0), '0);
      @(negedge clk);
      chk("dual_en", 0, 32'(ifa.out_en_o), 32'(5'b10010));
      chk("dual_pop", 0, 32'(ifa.in_pop_o), 32'(5'b00101));
      $display("dual grant: out_en=%b in_pop=%b", ifa.out_en_o, ifa.in_pop_o);
      next_edge();
      chk("dual_ret", 0, 32'(ifa.credit_ret_o), 32'(5'b00101));
      set_in('0, '0, '0);
      next_edge();
      chk("dual_ret_clear", 0, 32'(ifa.credit_ret_o), 0);

      // Wedge: L asks for absent W; then a credit into a full counter.
      do_reset();
      set_in(5'b10000, pack(0, 0, 0, 0, 3), '0);
      @(negedge clk);
      chk("wedge_no_en", 1, 32'(ifw.out_en_o), 0);
      chk("wedge_no_pop", 1, 32'(ifw.in_pop_o), 0);
      chk("full_w_en", 0, 32'(ifa.out_en_o), 32'(5'b01000));
      next_edge();
      chk("wedge_err_illegal", 1, 32'(ifw.err_o), 32'(2'b10));
      set_in('0, '0, 5'b00001);
      next_edge();
      chk("wedge_err_both", 1, 32'(ifw.err_o), 32'(2'b11));
      chk("wedge_cnt_sat", 1, 32'(ifw.credit_cnt_o[2:0]), 4);
      chk("full_err_ovf", 0, 32'(ifa.err_o), 32'(2'b01));
      $display("wedge: err=%b credit[N]=%0d", ifw.err_o, ifw.credit_cnt_o[2:0]);

      // Reset mid-operation with credit[E]=1 and ptr[E]=3.
      do_reset();
      set_in(5'b00100, pack(0, 0, 2, 0, 0), '0);
      repeat (3) next_edge();
      chk("mid_cnt_pre", 0, 32'(ifa.credit_cnt_o[8:6]), 1);
      set_in(5'b11111, pack(2, 2, 2, 2, 2), '0);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_no_en", 0, 32'(ifa.out_en_o), 0);
      next_edge();
      rst = 1'b1;
      chk("mid_cnt_reload", 0, 32'(ifa.credit_cnt_o[8:6]), 4);
      @(negedge clk);
      chk("mid_sel_n", 0, 32'(ifa.out_sel_o[8:6]), 0);
      chk("mid_en", 0, 32'(ifa.out_en_o[2]), 1);
      $display("mid reset: credit[E]=%0d out_sel[E]=%0d", ifa.credit_cnt_o[8:6], ifa.out_sel_o[8:6]);
      next_edge();

      // Random traffic, checked every cycle by the model.
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 199) != 0);
         for (int i = 0; i < 5; i++) begin
            s_valid[i] = ($urandom_range(0, 99) < 60);
            s_dest[3*i +: 3] = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(5, 7))
                                                            : 3'($urandom_range(0, 4));
            s_inc[i] = ($urandom_range(0, 99) < 45);
         end
         next_edge();
      end
      rst = 1'b1;
      set_in('0, '0, '0);
      next_edge();
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
